// File: rtl/cam_frame_tx.sv
// Synthetic OV7670-style camera source: streams RGB555 pixels from a two-bank
// frame memory as vsync/href/byte data, high byte first.
module cam_frame_tx #(
    parameter int H_ACTIVE  = 64,
    parameter int V_ACTIVE  = 48,
    parameter int H_BLANK   = 16,
    parameter int VSYNC_CYC = 32,
    parameter int VBP_CYC   = 16,
    parameter int VFP_CYC   = 16,
    parameter int BANK_SIZE = 3072
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        en,
    input  logic        frame_sel,
    input  logic [14:0] rd_data,
    output logic [12:0] rd_addr,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  cam_data,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [2:0] {IDLE, VSYNC, VBP, LINE, HBLANK, VFP} state_t;

    localparam logic [7:0]  VSYNC_LAST  = 8'(VSYNC_CYC - 1);
    localparam logic [7:0]  VBP_LAST    = 8'(VBP_CYC - 1);
    localparam logic [7:0]  VBP_FETCH   = 8'(VBP_CYC - 2);
    localparam logic [7:0]  LINE_LAST   = 8'(2 * H_ACTIVE - 1);
    localparam logic [7:0]  LINE_FETCH  = 8'(2 * H_ACTIVE - 4);
    localparam logic [7:0]  HBL_LAST    = 8'(H_BLANK - 1);
    localparam logic [7:0]  HBL_FETCH   = 8'(H_BLANK - 2);
    localparam logic [7:0]  VFP_LAST    = 8'(VFP_CYC - 1);
    localparam logic [5:0]  ROW_LAST    = 6'(V_ACTIVE - 1);
    localparam logic [12:0] BANK_OFF    = 13'(BANK_SIZE);

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [5:0]  line, line_nxt;
    logic        bank, bank_nxt;
    logic        start;
    logic        fetch;
    logic [12:0] pidx;
    logic [7:0]  lo_p1;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 8'd1;
        line_nxt  = line;
        bank_nxt  = bank;
        start     = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = 8'd0;
                if (en) begin
                    state_nxt = VSYNC;
                    bank_nxt  = frame_sel;
                    start     = 1'b1;
                end
            end
            VSYNC: if (cnt == VSYNC_LAST) begin state_nxt = VBP;    cnt_nxt = 8'd0; end
            VBP:   if (cnt == VBP_LAST)   begin state_nxt = LINE;   cnt_nxt = 8'd0; end
            LINE:  if (cnt == LINE_LAST)  begin state_nxt = HBLANK; cnt_nxt = 8'd0; end
            HBLANK: begin
                if (cnt == HBL_LAST) begin
                    cnt_nxt = 8'd0;
                    if (line == ROW_LAST) begin
                        state_nxt = VFP;
                        line_nxt  = 6'd0;
                    end else begin
                        state_nxt = LINE;
                        line_nxt  = line + 6'd1;
                    end
                end
            end
            VFP: begin
                if (cnt == VFP_LAST) begin
                    cnt_nxt = 8'd0;
                    if (en) begin
                        state_nxt = VSYNC;
                        bank_nxt  = frame_sel;
                        start     = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Address for a pixel goes out two cycles before its high byte: the first
    // pixel of a line is fetched from the blanking tail, the rest every 2 cycles.
    always_comb begin
        fetch = 1'b0;
        if (state_nxt == VBP && cnt_nxt == VBP_FETCH)
            fetch = 1'b1;
        else if (state_nxt == HBLANK && cnt_nxt == HBL_FETCH && line_nxt != ROW_LAST)
            fetch = 1'b1;
        else if (state_nxt == LINE && !cnt_nxt[0] && cnt_nxt <= LINE_FETCH)
            fetch = 1'b1;
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            cnt        <= 8'd0;
            line       <= 6'd0;
            bank       <= 1'b0;
            pidx       <= 13'd0;
            rd_addr    <= 13'd0;
            vsync      <= 1'b0;
            href       <= 1'b0;
            cam_data   <= 8'd0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            line       <= line_nxt;
            bank       <= bank_nxt;
            if (start) begin
                pidx <= 13'd0;
            end else if (fetch) begin
                pidx    <= pidx + 13'd1;
                rd_addr <= pidx + (bank ? BANK_OFF : 13'd0);
            end
            vsync      <= (state_nxt == VSYNC);
            href       <= (state_nxt == LINE);
            busy       <= (state_nxt != IDLE);
            frame_done <= (state_nxt == VFP) && (cnt_nxt == VFP_LAST);
            if (state_nxt == LINE)
                cam_data <= cnt_nxt[0] ? lo_p1 : {1'b0, rd_data[14:8]};
            else
                cam_data <= 8'd0;
        end
    end

    // Low byte is parked here while the high byte is on the bus.
    always_ff @(posedge pclk) begin
        if (state_nxt == LINE && !cnt_nxt[0])
            lo_p1 <= rd_data[7:0];
    end

endmodule

// File: tb/tb_cam_frame_tx.sv
// Directed bench for cam_frame_tx: frame timing, byte stream content, banks,
// continuous mode, en release and asynchronous reset.
module tb_cam_frame_tx;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        frame_sel = 1'b0;
    logic [14:0] rd_data = 15'd0;
    logic [12:0] rd_addr;
    logic        vsync, href, busy, frame_done;
    logic [7:0]  cam_data;

    int     errors = 0;
    int     checks = 0;
    int     mem_mode = 0;
    longint cyc = 0;
    longint s0, d0, s1, d1, s2, d2;
    int     acc;
    int     guard;

    cam_frame_tx dut (
        .pclk       (pclk),
        .rst        (rst),
        .en         (en),
        .frame_sel  (frame_sel),
        .rd_data    (rd_data),
        .rd_addr    (rd_addr),
        .vsync      (vsync),
        .href       (href),
        .cam_data   (cam_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    function automatic logic [14:0] mem_word(input logic [12:0] a, input int mode);
        int v;
        case (mode)
            1:       return {2'b00, a};
            2: begin
                v = int'(a) * 13 + 7;
                return 15'(v) ^ 15'h2AB5;
            end
            default: return 15'($urandom);
        endcase
    endfunction

    // Frame memory with one cycle of read latency.
    always @(posedge pclk) rd_data <= mem_word(rd_addr, mem_mode);

    task automatic check_val(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_frame(input string tag);
        en = 1'b1;
        @(negedge pclk);
        en = 1'b0;
        check_val({tag, " vsync_rise"}, vsync, 1);
    endtask

    // Walks one frame sample by sample from the vsync rise to frame_done.
    task automatic run_frame(input string tag, input logic exp_bank, input int drop_t,
                             input int toggle_t, output longint start_cyc, output longint done_cyc);
        int g = 0;
        int vs_cnt = 0, first_href = -1, lines = 0, run = 0;
        int bad_len = 0, byte_err = 0, viol = 0, done_t = -1;
        logic prev_href = 1'b0;
        logic [12:0] base, a;
        logic [14:0] w;
        logic [7:0]  eb;
        base = exp_bank ? 13'd3072 : 13'd0;
        done_cyc = -1;
        while (!vsync && g < 200) begin
            @(negedge pclk);
            g++;
        end
        check_val({tag, " vsync_seen"}, vsync, 1);
        start_cyc = cyc;
        for (int t = 0; t < 8000; t++) begin
            if (t == drop_t)   en = 1'b0;
            if (t == toggle_t) frame_sel = ~frame_sel;
            if (vsync) vs_cnt++;
            if (vsync && href) viol++;
            if (!href && cam_data != 8'd0) viol++;
            if (href) begin
                if (first_href < 0) first_href = t;
                a  = base + 13'(lines * 64 + run / 2);
                w  = mem_word(a, mem_mode);
                eb = run[0] ? w[7:0] : {1'b0, w[14:8]};
                if (cam_data !== eb) byte_err++;
                run++;
            end else if (prev_href) begin
                lines++;
                if (run != 128) bad_len++;
                run = 0;
            end
            prev_href = href;
            if (frame_done) begin
                done_t   = t;
                done_cyc = cyc;
                break;
            end
            @(negedge pclk);
        end
        check_val({tag, " vsync_len"}, vs_cnt, 32);
        check_val({tag, " first_href"}, first_href, 48);
        check_val({tag, " lines"}, lines, 48);
        check_val({tag, " bad_line_len"}, bad_len, 0);
        check_val({tag, " byte_err"}, byte_err, 0);
        check_val({tag, " sync_viol"}, viol, 0);
        check_val({tag, " done_t"}, done_t, 6975);
    endtask

    initial begin
        #1 rst = 1'b0;
        en = 1'b1;
        mem_mode = 0;
        repeat (5) @(negedge pclk);
        check_val("rst vsync", vsync, 0);
        check_val("rst href", href, 0);
        check_val("rst cam_data", cam_data, 0);
        check_val("rst busy", busy, 0);
        check_val("rst frame_done", frame_done, 0);
        check_val("rst rd_addr", rd_addr, 0);
        en = 1'b0;
        rst = 1'b1;
        acc = 0;
        repeat (20) begin
            @(negedge pclk);
            acc += int'(busy) + int'(vsync);
        end
        check_val("idle after rst", acc, 0);

        // single frame, bank 0, address pattern
        mem_mode = 1;
        frame_sel = 1'b0;
        start_frame("f0");
        run_frame("f0", 1'b0, -1, -1, s0, d0);
        check_val("f0 last rd_addr", rd_addr, 3071);
        @(negedge pclk);
        check_val("f0 idle vsync", vsync, 0);
        check_val("f0 idle busy", busy, 0);

        // bank 1, frame_sel toggled and en held then dropped mid line 20
        frame_sel = 1'b1;
        en = 1'b1;
        @(negedge pclk);
        check_val("b1 vsync_rise", vsync, 1);
        run_frame("b1", 1'b1, 2992, 1000, s0, d0);
        check_val("b1 last rd_addr", rd_addr, 6143);
        repeat (3) @(negedge pclk);
        check_val("b1 idle busy", busy, 0);

        // continuous: banks 0/1/0 with no gap
        frame_sel = 1'b0;
        en = 1'b1;
        @(negedge pclk);
        run_frame("c0", 1'b0, -1, 3000, s0, d0);
        run_frame("c1", 1'b1, -1, 3000, s1, d1);
        check_val("c1 gap", s1 - d0, 1);
        run_frame("c2", 1'b0, 3000, -1, s2, d2);
        check_val("c2 gap", s2 - d1, 1);
        @(negedge pclk);
        check_val("c idle busy", busy, 0);

        // asynchronous reset in the middle of a line
        start_frame("mr");
        guard = 0;
        while (!href && guard < 200) begin
            @(negedge pclk);
            guard++;
        end
        repeat (10) @(negedge pclk);
        check_val("mr href before", href, 1);
        #2 rst = 1'b0;
        #1;
        check_val("mr href", href, 0);
        check_val("mr vsync", vsync, 0);
        check_val("mr cam_data", cam_data, 0);
        check_val("mr busy", busy, 0);
        @(negedge pclk);
        rst = 1'b1;
        acc = 0;
        repeat (20) begin
            @(negedge pclk);
            acc += int'(busy) + int'(vsync) + int'(href);
        end
        check_val("mr idle after", acc, 0);

        // scrambled memory contents, bank 1
        mem_mode = 2;
        frame_sel = 1'b1;
        start_frame("lb");
        run_frame("lb", 1'b1, -1, -1, s0, d0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cam_frame_tx.md
# cam_frame_tx

Camera-side frame transmitter: reads 15-bit RGB555 pixels from a frame memory and emits them as an OV7670-style parallel byte stream (vsync, href, 8-bit data, two bytes per pixel, high byte first). It is the sending end of the camera capture path. It is used as a synthetic camera source for the capture logic and as a bench driver. It supports the same two-bank, 3072-pixel-per-bank buffer layout used by the capture side.

## Interface
- H_ACTIVE, 64, pixels per line
- V_ACTIVE, 48, lines per frame
- H_BLANK, 16, href-low cycles after each line
- VSYNC_CYC, 32, vsync-high cycles per frame
- VBP_CYC, 16, cycles from vsync fall to first href
- VFP_CYC, 16, cycles after last line's H_BLANK before frame end
- BANK_SIZE, 3072, pixel offset of bank 1
- pclk  in  1  sole clock; all outputs change on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  request frame transmission; sampled at frame boundaries only
- frame_sel  in  1  source bank; latched when a frame starts
- rd_data  in  15  pixel word from frame memory, valid the cycle after rd_addr
- rd_addr  out  13  frame memory read address
- vsync  out  1  frame sync, active high
- href  out  1  byte-valid line strobe, active high
- cam_data  out  8  byte stream
- busy  out  1  high from frame start through end of VFP
- frame_done  out  1  one-cycle pulse on last VFP cycle

## Operation
- States: IDLE, VSYNC, VBP, LINE, HBLANK, VFP.
- Reset (async, rst=0): state IDLE. All outputs are 0, the bank latch is 0, and all counters are 0.
- IDLE: vsync=href=0, cam_data=0, busy=0. If en=1 on a cycle, latch bank=frame_sel and enter VSYNC next cycle.
- VSYNC: vsync=1 for exactly VSYNC_CYC cycles, then VBP.
- VBP: vsync=0 and href=0 for VBP_CYC cycles, then LINE.
- LINE: href=1 for 2*H_ACTIVE cycles. On even byte phases, cam_data={1'b0, pix[14:8]}. On odd byte phases, cam_data=pix[7:0]. After the line, go to HBLANK.
- HBLANK: href=0 and cam_data=0 for H_BLANK cycles. Then go to LINE if lines remain, else VFP.
- VFP: VFP_CYC cycles, frame_done=1 on the last one. Next state is VSYNC if en=1 on that cycle (latch frame_sel anew, no idle gap), else IDLE.
- en and frame_sel are ignored mid-frame; deasserting en lets the current frame finish.
- Addressing: pixel index p = line*H_ACTIVE + col, in the range 0..H_ACTIVE*V_ACTIVE-1. rd_addr = p + (bank ? BANK_SIZE : 0), 13-bit, no wrap within a frame. The index resets to 0 at each frame start.
- rd_addr holds its last value outside LINE prefetch windows.
- href is never high while vsync is high; cam_data is 0 whenever href=0.

## Timing
- All outputs are registered.
- Frame period = VSYNC_CYC + VBP_CYC + V_ACTIVE*(2*H_ACTIVE+H_BLANK) + VFP_CYC. With the defaults this is 6976 cycles.
- vsync rises on the cycle after en is sampled high in IDLE.
- rd_addr for pixel p is driven exactly 2 cycles before the high byte of p appears on cam_data. rd_data is sampled 1 cycle after rd_addr and registered into the output path.
- For the first pixel of a line, rd_addr is driven during the last 2 cycles of VBP or HBLANK, so VBP_CYC and H_BLANK must each be at least 2.
- Within a line, addresses advance every 2 cycles.
- frame_done and the subsequent vsync rise are on consecutive cycles in continuous mode.
- Reset asserted mid-line forces href=0, vsync=0, and cam_data=0 immediately. After release, the first activity is a full VSYNC, and only if en=1.

## Test plan
- Reset check: hold rst=0 with en=1 and random rd_data → all outputs are 0. After release with en=0 → block stays IDLE and busy stays 0.
- Single frame, frame_sel=0, memory returns rd_data=addr, en pulsed for 1 cycle:
  - vsync is high for 32 cycles.
  - First href comes 16 cycles after vsync falls.
  - There are 48 lines of 128 href cycles each.
  - Bytes for pixel p are {0, p[14:8]} then p[7:0].
  - frame_done fires at cycle 6976 after vsync rise.
  - Block returns to IDLE.
- Bank 1: frame_sel=1 at start → rd_addr spans 3072..6143. Toggling frame_sel mid-frame has no effect on addresses.
- Continuous mode, en held 1, frame_sel toggled each frame → back-to-back frames with no gap, banks alternating 0/1/0.
- en dropped in the middle of line 20 → the frame completes with all 48 lines, then the block goes to IDLE.
- Loopback: feed the output to the capture block → captured 15-bit words equal the memory contents for all 3072 pixels, and the capture bank toggles once per frame.
